// File: rtl/int_crossing_pkg.sv
// Shared definitions for the interrupt sync crossing: hold-counter sizing,
// the legal hold ceiling and the state encoding used by edge-mode lines.
package int_crossing_pkg;

  localparam int MAX_MIN_HOLD = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOWHOLD = 2'd2
  } edge_state_e;

  // Counter holds MIN_HOLD-1, so clog2(MIN_HOLD) bits suffice; never narrower than 1 bit.
  function automatic int hold_cnt_width(input int min_hold);
    return (min_hold <= 2) ? 1 : $clog2(min_hold);
  endfunction

endpackage

// File: rtl/int_hold_cell.sv
// One interrupt line of the crossing source. Level mode forwards the input
// with a minimum hold on every transition; edge mode stretches each rising
// edge into a MIN_HOLD-cycle high followed by at least MIN_HOLD low cycles.
module int_hold_cell
  import int_crossing_pkg::*;
#(
  parameter int MIN_HOLD  = 4,
  parameter bit EDGE_MODE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic in_int,
  output logic out_sync,
  output logic busy,
  output logic coalesced
);

  localparam int            CW        = hold_cnt_width(MIN_HOLD);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_HOLD - 1);

  logic [CW-1:0] cnt;
  logic          prev;
  logic          pend;
  edge_state_e   state;
  logic          edge_det;

  assign edge_det = in_int & ~prev;

  // Per-line hold state; out_sync is a bare flop so nothing glitches across the crossing.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      out_sync <= 1'b0;
      prev     <= 1'b0;
      pend     <= 1'b0;
      state    <= IDLE;
    end else begin
      prev <= in_int;
      if (!EDGE_MODE) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (out_sync != in_int) begin
          out_sync <= in_int;
          cnt      <= HOLD_LOAD;
        end
      end else begin
        if (state == HIGH) begin
          if (edge_det) pend <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_sync <= 1'b0;
            cnt      <= HOLD_LOAD;
            state    <= LOWHOLD;
          end
        end else if (cnt != '0) begin
          if (edge_det) pend <= 1'b1;
          cnt <= cnt - 1'b1;
        end else if (edge_det || pend) begin
          // An expired low hold behaves exactly like IDLE so back-to-back pulses lose no cycle.
          out_sync <= 1'b1;
          cnt      <= HOLD_LOAD;
          pend     <= 1'b0;
          state    <= HIGH;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  // An edge arriving while one is already pending is merged; flag it for this cycle.
  always_comb begin
    coalesced = EDGE_MODE & ~reset & edge_det & pend;
    busy      = (cnt != '0) | pend;
  end

endmodule

// File: rtl/int_sync_crossing_source.sv
// Source side of the interrupt sync crossing: one independent hold cell per
// interrupt line, with the per-line busy flags merged into a single status.
module int_sync_crossing_source
  import int_crossing_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               MIN_HOLD  = 4,
  parameter logic [WIDTH-1:0] EDGE_MASK = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_int,
  output logic [WIDTH-1:0] out_sync,
  output logic             busy,
  output logic [WIDTH-1:0] coalesced
);

  logic [WIDTH-1:0] busy_line;

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    int_hold_cell #(
      .MIN_HOLD  (MIN_HOLD),
      .EDGE_MODE (EDGE_MASK[i])
    ) u_cell (
      .clock     (clock),
      .reset     (reset),
      .in_int    (in_int[i]),
      .out_sync  (out_sync[i]),
      .busy      (busy_line[i]),
      .coalesced (coalesced[i])
    );
  end

  // Any line still holding or pending keeps the block busy.
  always_comb begin
    busy = |busy_line;
  end

endmodule

// File: tb/tb_int_sync_crossing_source.sv
// Directed bench for the interrupt crossing source: level hold, glitch
// rejection, edge stretching and coalescing, mid-hold reset, and a
// MIN_HOLD=1 random register check.
module tb_int_sync_crossing_source;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // dut_a: two level lines, MIN_HOLD=4
  logic       rst_a;
  logic [1:0] in_a, out_a, coal_a;
  logic       busy_a;
  // dut_b: one edge line, MIN_HOLD=3
  logic       rst_b;
  logic [0:0] in_b, out_b, coal_b;
  logic       busy_b;
  // dut_c: eight level lines, MIN_HOLD=1
  logic       rst_c;
  logic [7:0] in_c, out_c, coal_c;
  logic       busy_c;

  int n_cmp = 0;
  int n_bad = 0;

  int_sync_crossing_source #(.WIDTH(2), .MIN_HOLD(4), .EDGE_MASK(2'b00)) dut_a (
    .clock(clock), .reset(rst_a), .in_int(in_a), .out_sync(out_a), .busy(busy_a), .coalesced(coal_a));
  int_sync_crossing_source #(.WIDTH(1), .MIN_HOLD(3), .EDGE_MASK(1'b1)) dut_b (
    .clock(clock), .reset(rst_b), .in_int(in_b), .out_sync(out_b), .busy(busy_b), .coalesced(coal_b));
  int_sync_crossing_source #(.WIDTH(8), .MIN_HOLD(1), .EDGE_MASK(8'h00)) dut_c (
    .clock(clock), .reset(rst_c), .in_int(in_c), .out_sync(out_c), .busy(busy_c), .coalesced(coal_c));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_c;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    in_a = '0; in_b = '0; in_c = '0;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    chk("a_rst_out", out_a, 2'b00);
    chk("a_rst_busy", busy_a, 1'b0);
    chk("a_rst_coal", coal_a, 2'b00);
    chk("b_rst_out", out_b, 1'b0);
    chk("b_rst_busy", busy_b, 1'b0);

    // Level line 0 rises, held 4 cycles
    in_a = 2'b01;                      // cycle 0
    tick(); chk("t1_out_c1", out_a, 2'b01); chk("t1_busy_c1", busy_a, 1'b1);
    tick(); chk("t1_busy_c2", busy_a, 1'b1);
    tick(); chk("t1_busy_c3", busy_a, 1'b1);
    tick(); chk("t1_busy_c4", busy_a, 1'b0); chk("t1_out_c4", out_a, 2'b01);
    in_a = 2'b00;
    tick(); chk("t1_fall_c5", out_a, 2'b00); chk("t1_fall_busy", busy_a, 1'b1);
    tick(); tick(); tick();
    chk("t1_idle_busy", busy_a, 1'b0);

    // Independent line 1
    in_a = 2'b10;
    tick(); chk("t1_line1", out_a, 2'b10);
    in_a = 2'b00;
    tick(); tick(); tick();
    chk("t1_line1_hold", out_a, 2'b10);
    tick(); chk("t1_line1_fall", out_a, 2'b00);
    tick(); tick(); tick();
    chk("t1_line1_idle", busy_a, 1'b0);

    // Glitch shorter than the hold: out still 1 for exactly 4 cycles
    in_a = 2'b01;                      // cycle 0
    tick(); chk("t2_c1", out_a, 2'b01);
    tick(); in_a = 2'b00;              // cycle 2
    tick(); chk("t2_c3", out_a, 2'b01);
    tick(); chk("t2_c4", out_a, 2'b01);
    tick(); chk("t2_c5", out_a, 2'b00);
    tick(); in_a = 2'b01;              // cycle 6: glitch back inside the low hold
    tick(); in_a = 2'b00;              // cycle 7
    tick(); tick();                    // cycle 9
    chk("t2_glitch_out", out_a, 2'b00);
    chk("t2_glitch_busy", busy_a, 1'b0);

    // Reset mid-hold
    in_a = 2'b01;                      // cycle 0
    tick(); chk("t5_c1", out_a, 2'b01);
    tick(); rst_a = 1'b1;              // cycle 2
    tick(); rst_a = 1'b0;              // cycle 3
    chk("t5_rst_out", out_a, 2'b00);
    chk("t5_rst_busy", busy_a, 1'b0);
    tick(); chk("t5_release", out_a, 2'b01);

    // Edge line: single pulse, MIN_HOLD=3
    in_b = 1'b1;                       // cycle 10
    tick(); in_b = 1'b0;
    chk("t3_c11", out_b, 1'b1); chk("t3_busy_c11", busy_b, 1'b1);
    tick(); chk("t3_c12", out_b, 1'b1);
    tick(); chk("t3_c13", out_b, 1'b1);
    tick(); chk("t3_c14", out_b, 1'b0); chk("t3_busy_c14", busy_b, 1'b1);
    tick(); tick(); chk("t3_c16", out_b, 1'b0);
    tick(); chk("t3_busy_c17", busy_b, 1'b0); chk("t3_c17", out_b, 1'b0);

    // Edge burst: pulses at cycles 0, 2, 4
    in_b = 1'b1;                       // cycle 0
    tick(); in_b = 1'b0; chk("t4_c1", out_b, 1'b1);
    tick(); in_b = 1'b1; #1;           // cycle 2
    chk("t4_coal_c2", coal_b, 1'b0);
    tick(); in_b = 1'b0; chk("t4_c3", out_b, 1'b1);
    tick(); in_b = 1'b1; #1;           // cycle 4
    chk("t4_c4", out_b, 1'b0);
    chk("t4_coal_c4", coal_b, 1'b1);
    tick(); in_b = 1'b0; #1;           // cycle 5
    chk("t4_coal_c5", coal_b, 1'b0);
    chk("t4_c5", out_b, 1'b0);
    tick(); chk("t4_c6", out_b, 1'b0);
    tick(); chk("t4_c7", out_b, 1'b1);
    tick(); tick(); chk("t4_c9", out_b, 1'b1);
    tick(); chk("t4_c10", out_b, 1'b0);
    tick(); tick(); tick(); chk("t4_c13", out_b, 1'b0);
    tick(); chk("t4_c14", out_b, 1'b0); chk("t4_busy_c14", busy_b, 1'b0);

    // Edge line held high through reset release fires once after release
    rst_b = 1'b1; in_b = 1'b1;
    tick(); tick();
    rst_b = 1'b0;
    chk("t3_rst_out", out_b, 1'b0);
    tick(); chk("t3_post_rst_edge", out_b, 1'b1);
    in_b = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick(); tick();

    // MIN_HOLD=1: plain register
    for (int i = 0; i < 1000; i++) begin
      in_c = 8'($urandom);
      exp_c = in_c;
      tick();
      chk("t6_reg", out_c, exp_c);
    end
    chk("t6_busy", busy_c, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
